// File: rtl/simd_perm_out_serializer.sv
// simd_perm_out_serializer: two-deep buffer of permuted vectors that
// drains each vector as NumBanks beats of NumLanes elements.
// Ports: clock/reset (sync, active-high); io_in* vector valid/ready/data;
// io_out* beat valid/ready/data plus beat index and last flag.
// Optional OUT_SER_PERF_CNT_EN adds io_stallCycles and io_vecDone.
module simd_perm_out_serializer #(
    parameter int XLEN     = 64,
    parameter int NumLanes = 8,
    parameter int NumBanks = 8,
    localparam int NumInOuts = NumLanes * NumBanks,
    localparam int BeatW     = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                io_inValid,
    output logic                                io_inReady,
    input  logic [NumInOuts-1:0][XLEN-1:0]      io_inData,
    output logic                                io_outValid,
    input  logic                                io_outReady,
    output logic [NumLanes-1:0][XLEN-1:0]       io_outData,
    output logic [BeatW-1:0]                    io_outBeat,
    output logic                                io_outLast
`ifdef OUT_SER_PERF_CNT_EN
    ,
    output logic [31:0]                         io_stallCycles,
    output logic [31:0]                         io_vecDone
`endif
);

    // Element e = bank*NumLanes + lane, so a flat vector reshapes
    // directly into [bank][lane] without reordering.
    typedef logic [NumBanks-1:0][NumLanes-1:0][XLEN-1:0] vec_t;

    localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBanks - 1);

    vec_t             r_entry [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [BeatW-1:0] r_beat;

    logic             w_accept;
    logic             w_fire;
    logic             w_last;
    logic             w_retire;
    vec_t             w_rd_vec;

    // Ready depends only on registered occupancy; a slot freed by a
    // retiring beat becomes visible one cycle later.
    assign io_inReady  = !reset && (r_count != 2'd2);
    assign io_outValid = (r_count != 2'd0);

    assign w_accept = io_inValid && io_inReady;
    assign w_fire   = io_outValid && io_outReady;
    assign w_last   = (r_beat == LastBeat);
    assign w_retire = w_fire && w_last;

    assign w_rd_vec   = r_entry[r_rd_ptr];
    assign io_outData = io_outValid ? w_rd_vec[r_beat] : '0;
    assign io_outBeat = r_beat;
    assign io_outLast = io_outValid && w_last;

    // Payload storage is not reset; only written on a handshake.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_entry[r_wr_ptr] <= vec_t'(io_inData);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_beat   <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_fire) begin
                if (w_last) begin
                    r_beat   <= '0;
                    r_rd_ptr <= ~r_rd_ptr;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_retire};
        end
    end

`ifdef OUT_SER_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_vec_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_vec_cnt   <= '0;
        end else begin
            // Stall count saturates; vector count wraps.
            if (io_outValid && !io_outReady && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_retire) begin
                r_vec_cnt <= r_vec_cnt + 32'd1;
            end
        end
    end

    assign io_stallCycles = r_stall_cnt;
    assign io_vecDone     = r_vec_cnt;
`endif

endmodule

// File: tb/tb_simd_perm_out_serializer.sv
// tb_simd_perm_out_serializer: directed + random stimulus checked
// against a queue-of-vectors reference model.
module tb_simd_perm_out_serializer;

    localparam int XLEN  = 64;
    localparam int NL    = 8;
    localparam int NB    = 8;
    localparam int NE    = NL * NB;
    localparam int BW    = 3;
    localparam int DW    = NL * XLEN;

    typedef logic [NE-1:0][XLEN-1:0] vec_t;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  io_inValid;
    logic                  io_inReady;
    vec_t                  io_inData;
    logic                  io_outValid;
    logic                  io_outReady;
    logic [NL-1:0][XLEN-1:0] io_outData;
    logic [BW-1:0]         io_outBeat;
    logic                  io_outLast;
`ifdef OUT_SER_PERF_CNT_EN
    logic [31:0]           io_stallCycles;
    logic [31:0]           io_vecDone;
`endif

    simd_perm_out_serializer #(
        .XLEN(XLEN), .NumLanes(NL), .NumBanks(NB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_inValid(io_inValid),
        .io_inReady(io_inReady),
        .io_inData(io_inData),
        .io_outValid(io_outValid),
        .io_outReady(io_outReady),
        .io_outData(io_outData),
        .io_outBeat(io_outBeat),
        .io_outLast(io_outLast)
`ifdef OUT_SER_PERF_CNT_EN
        ,
        .io_stallCycles(io_stallCycles),
        .io_vecDone(io_vecDone)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: FIFO of whole vectors plus beat position.
    vec_t        q[$];
    int          m_beat = 0;
    longint      m_stall = 0;
    longint      m_done = 0;
    bit          m_acc;
    vec_t        pend;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
        end
    endtask

    function automatic vec_t ramp_vec(input int base);
        vec_t v;
        for (int e = 0; e < NE; e++) v[e] = 64'(base + e);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int e = 0; e < NE; e++) v[e] = {$urandom, $urandom};
        return v;
    endfunction

    task automatic step(input logic rst, input logic iv, input logic ordy,
                        input bit chk_en);
        logic [DW-1:0] exp_d;
        vec_t          head;
        bit            fire;
        bit            stall;
        int            occ;
        reset       = rst;
        io_inValid  = iv;
        io_outReady = ordy;
        io_inData   = pend;
        #1;
        occ   = q.size();
        exp_d = '0;
        if (occ != 0) begin
            head = q[0];
            for (int l = 0; l < NL; l++)
                exp_d[l*XLEN +: XLEN] = head[m_beat*NL + l];
        end
        if (chk_en) begin
            chk("inReady", DW'(io_inReady), DW'(!rst && occ < 2));
            chk("outValid", DW'(io_outValid), DW'(occ != 0));
            chk("outBeat", DW'(io_outBeat), DW'(m_beat));
            chk("outLast", DW'(io_outLast),
                DW'(occ != 0 && m_beat == NB - 1));
            chk("outData", io_outData, exp_d);
`ifdef OUT_SER_PERF_CNT_EN
            chk("stallCycles", DW'(io_stallCycles), DW'(m_stall));
            chk("vecDone", DW'(io_vecDone), DW'(m_done % 64'h1_0000_0000));
`endif
        end
        m_acc = iv && !rst && occ < 2;
        fire  = occ != 0 && ordy;
        stall = occ != 0 && !ordy;
        @(posedge clock);
        if (rst) begin
            q.delete();
            m_beat  = 0;
            m_stall = 0;
            m_done  = 0;
        end else begin
            if (stall && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (fire) begin
                if (m_beat == NB - 1) begin
                    void'(q.pop_front());
                    m_beat = 0;
                    m_done++;
                end else begin
                    m_beat++;
                end
            end
            if (m_acc) q.push_back(pend);
        end
        #1;
    endtask

    initial begin
        int n;
        int g;
        pend = rand_vec();
        step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);

        // Single ramp vector, consumer always ready.
        pend = ramp_vec('h1000);
        step(0, 1, 1, 1);
        repeat (10) step(0, 0, 1, 1);

        // Three vectors offered while consumer stalls, then released.
        n = 0;
        g = 0;
        pend = ramp_vec('h2000);
        while (n < 3 && g < 60) begin
            step(0, 1, g >= 6, 1);
            if (m_acc) begin
                n++;
                pend = ramp_vec('h2000 + 'h100 * n);
            end
            g++;
        end
        chk("three_accepted", DW'(n), DW'(3));
        repeat (30) step(0, 0, 1, 1);

        // Ready toggling mid-vector.
        pend = ramp_vec('h3000);
        step(0, 1, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 0, (i % 2) == 1, 1);

        // Full buffer while the last beat retires and upstream waits.
        pend = rand_vec();
        step(0, 1, 0, 1);
        pend = rand_vec();
        step(0, 1, 0, 1);
        pend = rand_vec();
        for (int i = 0; i < 30; i++) begin
            step(0, 1, 1, 1);
            if (m_acc) pend = rand_vec();
        end
        repeat (20) step(0, 0, 1, 1);

        // Reset with a partially drained vector and one buffered.
        pend = rand_vec();
        step(0, 1, 0, 1);
        pend = rand_vec();
        step(0, 1, 0, 1);
        repeat (3) step(0, 0, 1, 1);
        step(1, 1, 1, 1);
        pend = ramp_vec('h5000);
        step(0, 1, 1, 1);
        repeat (10) step(0, 0, 1, 1);

        // Random traffic with occasional reset.
        pend = rand_vec();
        for (int i = 0; i < 800; i++) begin
            logic r;
            logic v;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 2) != 0);
            step(r, v, $urandom_range(0, 3) != 0, 1);
            if (m_acc || !v) pend = rand_vec();
        end
        repeat (20) step(0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
